// File: rtl/powlib_ipmemtest.sv
// powlib_ipmemtest -- memory-test bus master for the RAM slaves behind a crossbar port.
//
// On start it writes T_WORDS pattern words (SEED+i) to T_BASE, then issues read
// requests for the same words, with responses returned to B_BASE+B_BPD*i. It checks each
// response against the expected pattern, then reports done, pass and a saturating
// error count.
//
// Ports:
//   clk, rst (async, active-low), start (pulse, honoured in IDLE/DONE only)
//   busy, done, pass, errcnt[15:0], firsterr[B_AW-1:0]      status
//   wraddr, wrdata, wrvld / wrrdy                           request channel
//   rdaddr, rddata, rdvld / rdrdy                           response channel
//   Packets are {op, be, data} with data at the LSBs.
//
// Optional feature macro: POWLIB_IPMEMTEST_FIRSTERR_EN
//   defined   -> firsterr holds the target address of the first mismatch of a run
//   undefined -> firsterr is tied to zero
//
// B_BPD must be a power of two (word index is derived by shifting).

`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif

module powlib_ipmemtest #(
   parameter string           ID      = "MEMTEST",
   parameter int              EAR     = 0,
   parameter int              EDBG    = 0,
   parameter int              B_BPD   = 4,
   parameter int              B_AW    = 32,
   parameter int              B_OPW   = `POWLIB_OPW,
   parameter int              OP_WR   = 0,
   parameter int              OP_RD   = 1,
   parameter logic [B_AW-1:0] B_BASE  = 32'h50030000,
   parameter logic [B_AW-1:0] T_BASE  = 32'h50010000,
   parameter int              T_WORDS = 64,
   parameter logic [31:0]     SEED    = 32'hA5A50000,
   parameter int              MAX_OUT = 4,
   localparam int             B_DW    = 8*B_BPD,
   localparam int             B_PW    = B_DW+B_BPD+B_OPW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [15:0]     errcnt,
   output logic [B_AW-1:0] firsterr,
   output logic [B_AW-1:0] wraddr,
   output logic [B_PW-1:0] wrdata,
   output logic            wrvld,
   input  logic            wrrdy,
   input  logic [B_AW-1:0] rdaddr,
   input  logic [B_PW-1:0] rddata,
   input  logic            rdvld,
   output logic            rdrdy
);

   localparam int BSH = $clog2(B_BPD);
   localparam int IW  = 17;
   localparam logic [IW-1:0] LAST = IW'(T_WORDS-1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DONE} state_t;

   function automatic logic [B_AW-1:0] word_addr(input logic [B_AW-1:0] base, input logic [IW-1:0] i);
      return base + (B_AW'(i) << BSH);
   endfunction

   function automatic logic [B_DW-1:0] pattern(input logic [B_AW-1:0] i);
      return B_DW'(SEED) + B_DW'(i);
   endfunction

   function automatic logic [B_PW-1:0] make_pkt(input int op, input logic [B_DW-1:0] data);
      return {B_OPW'(op), {B_BPD{1'b1}}, data};
   endfunction

   state_t          state_r;
   logic [IW-1:0]   idx_r;
   logic [3:0]      outst_r;
   logic            req_vld_r;
   logic [B_AW-1:0] req_addr_r;
   logic [B_PW-1:0] req_data_r;
   logic            rdrdy_r, busy_r, done_r;
   logic [15:0]     errcnt_r;

   logic            req_rdy_s, acc_req_s, acc_rd_s, acc_rsp_s, dec_s, can_issue_s, start_ok_s;
   logic [3:0]      outst_next_s;
   logic [IW-1:0]   nxt_idx_s;
   logic            chk_vld_s, chk_pend_s, bad_s;
   logic [B_AW-1:0] chk_addr_s, j_s;
   logic [B_DW-1:0] chk_word_s;

   assign acc_req_s    = req_vld_r && req_rdy_s;
   assign acc_rd_s     = acc_req_s && (state_r == S_READ);
   assign acc_rsp_s    = rdvld && rdrdy_r;
   // a stray response with nothing outstanding is still checked but must not underflow the count
   assign dec_s        = acc_rsp_s && (outst_r != 4'd0);
   assign outst_next_s = outst_r + {3'b000, acc_rd_s} - {3'b000, dec_s};
   assign can_issue_s  = outst_next_s < 4'(MAX_OUT);
   assign start_ok_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign nxt_idx_s    = idx_r + 17'd1;

   // Main sequencer: write phase, read phase with outstanding limit, drain, done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= S_IDLE;
         idx_r      <= '0;
         outst_r    <= 4'd0;
         req_vld_r  <= 1'b0;
         req_addr_r <= '0;
         req_data_r <= '0;
         rdrdy_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         outst_r <= outst_next_s;
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_r    <= S_WRITE;
                  idx_r      <= '0;
                  req_vld_r  <= 1'b1;
                  req_addr_r <= word_addr(T_BASE, '0);
                  req_data_r <= make_pkt(OP_WR, pattern('0));
                  busy_r     <= 1'b1;
                  done_r     <= 1'b0;
               end
            end
            S_WRITE: begin
               if (acc_req_s) begin
                  if (idx_r == LAST) begin
                     // nothing is outstanding yet, so the first read can go out at once
                     state_r    <= S_READ;
                     idx_r      <= '0;
                     req_addr_r <= word_addr(T_BASE, '0);
                     req_data_r <= make_pkt(OP_RD, B_DW'(word_addr(B_BASE, '0)));
                     rdrdy_r    <= 1'b1;
                  end else begin
                     idx_r      <= nxt_idx_s;
                     req_addr_r <= word_addr(T_BASE, nxt_idx_s);
                     req_data_r <= make_pkt(OP_WR, pattern(B_AW'(nxt_idx_s)));
                  end
               end
            end
            S_READ: begin
               if (acc_req_s) begin
                  if (idx_r == LAST) begin
                     state_r   <= S_WAIT;
                     req_vld_r <= 1'b0;
                  end else begin
                     idx_r      <= nxt_idx_s;
                     req_addr_r <= word_addr(T_BASE, nxt_idx_s);
                     req_data_r <= make_pkt(OP_RD, B_DW'(word_addr(B_BASE, nxt_idx_s)));
                     req_vld_r  <= can_issue_s;
                  end
               end else if (!req_vld_r) begin
                  // a raised request is never withdrawn; only an idle one waits for credit
                  req_vld_r <= can_issue_s;
               end
            end
            S_WAIT: begin
               if ((outst_r == 4'd0) && !chk_pend_s) begin
                  state_r <= S_DONE;
                  rdrdy_r <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end

   generate
      if (EAR == 0) begin : g_req_direct
         assign wrvld     = req_vld_r;
         assign wraddr    = req_addr_r;
         assign wrdata    = req_data_r;
         assign req_rdy_s = wrrdy;

         assign chk_vld_s  = acc_rsp_s;
         assign chk_addr_s = rdaddr;
         assign chk_word_s = rddata[B_DW-1:0];
         assign chk_pend_s = 1'b0;
      end else begin : g_req_reg
         logic            ovld_r;
         logic [B_AW-1:0] oaddr_r;
         logic [B_PW-1:0] odata_r;
         logic            cvld_r;
         logic [B_AW-1:0] caddr_r;
         logic [B_DW-1:0] cword_r;

         // Output slice: reloads only when empty or draining, so a held request stays stable.
         assign req_rdy_s = !ovld_r || wrrdy;

         // Request register stage.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ovld_r  <= 1'b0;
               oaddr_r <= '0;
               odata_r <= '0;
            end else if (req_rdy_s) begin
               ovld_r  <= req_vld_r;
               oaddr_r <= req_addr_r;
               odata_r <= req_data_r;
            end else begin
               ovld_r  <= ovld_r;
            end
         end

         // Response register stage; the check runs one cycle after acceptance.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cvld_r  <= 1'b0;
               caddr_r <= '0;
               cword_r <= '0;
            end else begin
               cvld_r <= acc_rsp_s;
               if (acc_rsp_s) begin
                  caddr_r <= rdaddr;
                  cword_r <= rddata[B_DW-1:0];
               end else begin
                  caddr_r <= caddr_r;
               end
            end
         end

         assign wrvld      = ovld_r;
         assign wraddr     = oaddr_r;
         assign wrdata     = odata_r;
         assign chk_vld_s  = cvld_r;
         assign chk_addr_s = caddr_r;
         assign chk_word_s = cword_r;
         assign chk_pend_s = cvld_r;
      end
   endgenerate

   // Response index; an address below B_BASE wraps to a huge index and counts as out of range.
   assign j_s   = (chk_addr_s - B_BASE) >> BSH;
   assign bad_s = chk_vld_s && ((j_s >= B_AW'(T_WORDS)) || (chk_word_s != pattern(j_s)));

   // Saturating mismatch counter, cleared by an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         errcnt_r <= 16'd0;
      end else if (start_ok_s) begin
         errcnt_r <= 16'd0;
      end else if (bad_s && (errcnt_r != 16'hFFFF)) begin
         errcnt_r <= errcnt_r + 16'd1;
      end else begin
         errcnt_r <= errcnt_r;
      end
   end

`ifdef POWLIB_IPMEMTEST_FIRSTERR_EN
   logic [B_AW-1:0] firsterr_r;
   // Capture the target address of the first mismatch of the run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         firsterr_r <= '0;
      end else if (start_ok_s) begin
         firsterr_r <= '0;
      end else if (bad_s && (errcnt_r == 16'd0)) begin
         firsterr_r <= T_BASE + (j_s << BSH);
      end else begin
         firsterr_r <= firsterr_r;
      end
   end
   assign firsterr = firsterr_r;
`else
   assign firsterr = '0;
`endif

   // Opcode and byte-enable fields of responses carry no information for the check.
   logic unused_rsp_fields;
   assign unused_rsp_fields = ^rddata[B_PW-1:B_DW];

   assign busy   = busy_r;
   assign done   = done_r;
   assign pass   = done_r && (errcnt_r == 16'd0);
   assign errcnt = errcnt_r;
   assign rdrdy  = rdrdy_r;

endmodule

// File: tb/tb_powlib_ipmemtest.sv
module tb_powlib_ipmemtest;
   localparam int T  = 8;
   localparam int MO = 4;
   localparam logic [31:0] TB = 32'h50010000;
   localparam logic [31:0] BB = 32'h50030000;
   localparam logic [31:0] SD = 32'hA5A50000;
`ifdef POWLIB_IPMEMTEST_FIRSTERR_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic        busy, done, pass, wrvld, rdrdy;
   logic [15:0] errcnt;
   logic [31:0] firsterr, wraddr;
   logic [37:0] wrdata;
   logic        wrrdy = 1'b0, rdvld = 1'b0;
   logic [31:0] rdaddr = 32'h0;
   logic [37:0] rddata = 38'h0;

   powlib_ipmemtest #(.EAR(0), .B_OPW(2), .T_WORDS(T), .MAX_OUT(MO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .errcnt(errcnt), .firsterr(firsterr), .wraddr(wraddr), .wrdata(wrdata),
      .wrvld(wrvld), .wrrdy(wrrdy), .rdaddr(rdaddr), .rddata(rddata),
      .rdvld(rdvld), .rdrdy(rdrdy));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          corrupt;   // word index the slave returns as 0 (-1 none)
      int          badj;      // word index whose response address is pushed out of range (-1 none)
      bit          rnd;       // wrrdy random 50%
      bit          rev;       // responses returned newest-first
      bit          hold;      // responses withheld for 30 cycles after start
      bit          bstart;    // extra start pulse while busy
      int          exp_err;
      bit          exp_pass;
      logic [31:0] exp_ferr;  // expected firsterr when the capture feature is built
   } vec_t;

   vec_t        vecs[6];
   vec_t        cur;
   int          n_vec = 0, n_miss = 0;
   logic [63:0] q[$];
   logic [31:0] mem[T];
   int          writes, reads, outst, max_out, seq_bad, stab_bad, hold_cnt, snap_reads, snap_wrvld;
   bit          rd_taken, prev_stall;
   logic [31:0] prev_addr;
   logic [37:0] prev_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic init_model();
      q.delete();
      writes = 0; reads = 0; outst = 0; max_out = 0; seq_bad = 0; stab_bad = 0;
      rd_taken = 1'b0; prev_stall = 1'b0; snap_reads = -1; snap_wrvld = -1;
      rdvld = 1'b0;
   endtask

   // One clock: entered and left at a falling edge; drives inputs, models the RAM slave.
   task automatic cycle();
      logic [31:0] ca, ra, word;
      logic [37:0] cd;
      logic [63:0] e;
      bit          wx, rx;
      int          k;
      if (prev_stall && (wrvld !== 1'b1 || wraddr !== prev_addr || wrdata !== prev_data)) stab_bad++;
      if (rd_taken) rdvld = 1'b0;
      wrrdy = cur.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_cnt == 1) begin snap_reads = reads; snap_wrvld = int'(wrvld); end
      if (!rdvld && q.size() > 0 && hold_cnt == 0 && (!cur.rev || q.size() >= MO || reads == T)) begin
         k = cur.rev ? q.size() - 1 : 0;
         e = q[k];
         q.delete(k);
         rdaddr = e[63:32];
         rddata = {2'd1, 4'hF, e[31:0]};
         rdvld  = 1'b1;
      end
      wx = wrvld && wrrdy;
      rx = rdvld && rdrdy;
      ca = wraddr; cd = wrdata;
      prev_stall = wrvld && !wrrdy; prev_addr = ca; prev_data = cd;
      if (hold_cnt > 0) hold_cnt--;
      @(posedge clk);
      if (wx) begin
         if (writes < T) begin
            if (ca !== TB + 32'(4*writes) || cd !== {2'd0, 4'hF, SD + 32'(writes)}) seq_bad++;
            mem[writes] = cd[31:0];
            writes++;
         end else begin
            if (ca !== TB + 32'(4*reads) || cd !== {2'd1, 4'hF, BB + 32'(4*reads)}) seq_bad++;
            k = int'((ca - TB) >> 2);
            word = (k >= 0 && k < T) ? mem[k] : 32'h0;
            if (k == cur.corrupt) word = 32'h0;
            ra = cd[31:0];
            if (k == cur.badj) ra = BB + 32'd32;
            q.push_back({ra, word});
            reads++; outst++;
            if (outst > max_out) max_out = outst;
         end
      end
      if (rx) outst--;
      rd_taken = rx;
      @(negedge clk);
   endtask

   task automatic run_test(input vec_t v);
      int n;
      cur = v;
      init_model();
      hold_cnt = v.hold ? 30 : 0;
      start = 1'b1; cycle(); start = 1'b0;
      chk({v.name, ":start_busy_vld"}, {busy, wrvld}, 2'b11);
      chk({v.name, ":errcnt_clr"}, errcnt, 16'd0);
      n = 0;
      while (!done && n < 2000) begin
         if (v.bstart && n == 3) start = 1'b1;
         cycle();
         start = 1'b0;
         n++;
      end
      rdvld = 1'b0;
      chk({v.name, ":done"}, done, 1'b1);
      chk({v.name, ":pass"}, pass, v.exp_pass);
      chk({v.name, ":errcnt"}, errcnt, 16'(v.exp_err));
      chk({v.name, ":firsterr"}, firsterr, FE ? v.exp_ferr : 32'h0);
      chk({v.name, ":busy_rdrdy"}, {busy, rdrdy}, 2'b00);
      chk({v.name, ":writes"}, writes, T);
      chk({v.name, ":reads"}, reads, T);
      chk({v.name, ":req_seq"}, seq_bad, 0);
      chk({v.name, ":req_stable"}, stab_bad, 0);
      chk({v.name, ":max_out_ok"}, max_out <= MO, 1'b1);
      chk({v.name, ":drained"}, {q.size() == 0, outst == 0}, 2'b11);
      if (v.hold) begin
         chk({v.name, ":reads_at_hold"}, snap_reads, MO);
         chk({v.name, ":wrvld_at_hold"}, snap_wrvld, 0);
      end
   endtask

   initial begin
      int n, bad;
      vecs[0] = '{"ideal",       -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0};
      vecs[1] = '{"corrupt3",     3, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h5001000C};
      vecs[2] = '{"rnd_rev",     -1, -1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 32'h0};
      vecs[3] = '{"hold",        -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 32'h0};
      vecs[4] = '{"badj5",       -1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h50010020};
      vecs[5] = '{"corrupt6rev",  6, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 32'h50010018};

      cur = vecs[0];
      init_model();
      @(negedge clk); @(negedge clk);
      chk("reset:ctl", {wrvld, rdrdy, busy, done, pass}, 5'b00000);
      chk("reset:errcnt", errcnt, 16'd0);
      chk("reset:firsterr", firsterr, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle:no_start", {busy, wrvld}, 2'b00);

      for (int i = 0; i < 6; i++) run_test(vecs[i]);

      // abort mid-read with two reads outstanding
      cur = vecs[0];
      init_model();
      hold_cnt = 1000;
      start = 1'b1; cycle(); start = 1'b0;
      n = 0;
      while (outst < 2 && n < 200) begin cycle(); n++; end
      chk("rst:two_out", outst, 2);
      rst = 1'b0;
      #1;
      chk("rst:ctl", {wrvld, rdrdy, busy, done, pass}, 5'b00000);
      chk("rst:errcnt", errcnt, 16'd0);
      chk("rst:firsterr", firsterr, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      rdvld = 1'b1; rdaddr = BB; rddata = {2'd1, 4'hF, 32'hDEAD0000};
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdrdy !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("rst:late_rsp_refused", bad, 0);
      chk("rst:late_errcnt", errcnt, 16'd0);
      rdvld = 1'b0;
      cur = vecs[0];
      cur.name = "after_rst";
      run_test(cur);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
